// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot flush, load-use, branch
// flush, memory-wait freeze with timeout, and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int BOOT_FLUSH  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rd_e_i,
  input  logic             mem_read_e_i,
  input  logic             pc_src_e_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ready_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, ERROR} state_e;

  localparam int BC_W = (BOOT_FLUSH > 1) ? $clog2(BOOT_FLUSH) : 1;
  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [BC_W-1:0] BOOT_INIT = BC_W'(BOOT_FLUSH - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              mem_stall, load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    mem_stall = mem_req_m_i && !mem_ready_i;
    load_use  = mem_read_e_i && (rd_e_i != 5'd0) &&
                ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    stall_f_o   = 1'b0;
    stall_d_o   = 1'b0;
    stall_e_o   = 1'b0;
    stall_m_o   = 1'b0;
    flush_d_o   = 1'b0;
    flush_e_o   = 1'b0;
    flush_w_o   = 1'b0;

    case (state_q)
      BOOT: begin
        stall_f_o = 1'b1;
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
        if (boot_cnt_q == '0) state_d = RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end
      RUN, MEM_WAIT: begin
        // Memory freeze outranks the branch flush so a resolved branch stays in E.
        if (mem_stall) begin
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          stall_e_o = 1'b1;
          stall_m_o = 1'b1;
          flush_w_o = 1'b1;
        end else if (pc_src_e_i) begin
          flush_d_o = 1'b1;
          flush_e_o = 1'b1;
        end else if (load_use) begin
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          flush_e_o = 1'b1;
        end
        if (mem_stall || (!pc_src_e_i && load_use)) stall_cnt_d = sat_inc(stall_cnt_q);

        if (mem_stall) begin
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WC_W'(1);
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
        stall_m_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      boot_cnt_q  <= BOOT_INIT;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a reference model pushes expected
// output vectors as stimulus is driven; they are popped and compared at negedge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        mr, ps, mq, my;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w, mem_err;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  // reference model state: 0 BOOT, 1 RUN, 2 MEM_WAIT, 3 ERROR
  int          m_state, m_boot, m_wait;
  logic        m_err;
  logic [31:0] m_cnt;

  localparam logic [63:0] BOOT_VEC = {24'd0, 7'b1000110, 1'b0, 32'd0};

  pipeline_ctrl #(.BOOT_FLUSH(4), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_d_i(rs1), .rs2_d_i(rs2), .rd_e_i(rd),
    .mem_read_e_i(mr), .pc_src_e_i(ps), .mem_req_m_i(mq), .mem_ready_i(my),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
    .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_w_o(flush_w),
    .mem_err_o(mem_err), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dut_vec();
    return {24'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
            mem_err, stall_cnt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_boot = 3; m_wait = 0; m_err = 1'b0; m_cnt = 32'd0;
  endtask

  function automatic logic [63:0] model_out();
    logic [6:0] v;
    logic       lu;
    lu = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    if (m_state == 0)        v = 7'b1000110;
    else if (m_state == 3)   v = 7'b1111000;
    else if (mq && !my)      v = 7'b1111001;
    else if (ps)             v = 7'b0000110;
    else if (lu)             v = 7'b1100010;
    else                     v = 7'b0000000;
    return {24'd0, v, m_err, m_cnt};
  endfunction

  task automatic model_advance(input logic [63:0] o);
    case (m_state)
      0: if (m_boot == 0) m_state = 1; else m_boot--;
      1, 2: begin
        if (o[39] && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (mq && !my) begin
          if (m_state == 1) begin m_state = 2; m_wait = 1; end
          else if (m_wait == 15) begin m_state = 3; m_err = 1'b1; end
          else m_wait++;
        end else begin
          m_state = 1; m_wait = 0;
        end
      end
      default: ;
    endcase
  endtask

  // Entered just after a posedge; drives, pushes expectation, checks at negedge.
  task automatic cyc(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] d, input logic r, input logic p,
                     input logic q, input logic y);
    logic [63:0] e;
    rs1 = a1; rs2 = a2; rd = d; mr = r; ps = p; mq = q; my = y;
    e = model_out();
    sb_q.push_back(e);
    model_advance(e);
    @(negedge clk);
    chk(tag, dut_vec(), sb_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous return to BOOT values.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk(tag, dut_vec(), BOOT_VEC);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle({tag, "_boot"});
    idle({tag, "_run"});
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; mr = 0; ps = 0; mq = 0; my = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_reset", dut_vec(), BOOT_VEC);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) idle("boot");
    idle("run_idle");
    chk("cnt_after_boot", {32'd0, stall_cnt}, 64'd0);

    cyc("load_use", 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rd0", 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnt_lu", {32'd0, stall_cnt}, 64'd1);
    cyc("br_lu", 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("after_br");
    chk("cnt_br", {32'd0, stall_cnt}, 64'd1);

    for (int i = 0; i < 3; i++) cyc("mem_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mem_done", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cnt_mem", {32'd0, stall_cnt}, 64'd4);
    cyc("br_held", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("br_release", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++)
      cyc("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0));

    async_reset("rst_pre_to");
    for (int i = 0; i < 16; i++) cyc("to_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("err_hold", 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("err_flag", {63'd0, mem_err}, 64'd1);
    chk("err_cnt", {32'd0, stall_cnt}, 64'd16);
    async_reset("rst_in_err");

    for (int i = 0; i < 4; i++) cyc("mw_pre", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rs1 = '0; rs2 = '0; rd = '0; mr = 0; ps = 0; mq = 1; my = 0;
    async_reset("rst_in_mw");
    cyc("mw_after", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
